// File: rtl/spi_pkg.sv
// Shared SPI definitions: default bus geometry and the receive FSM states.
package spi_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned LINES_DEF      = 6;

    typedef enum logic {
        StIdle,
        StRecv
    } spi_state_e;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop single-bit synchronizer with a configurable reset value.
module synchronizer #(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic [DEPTH-1:0] stage_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/spi_par_receiver.sv
// Multi-line SPI receiver: every line shifts one pixel word MSB first on the
// rising chip clock while chip select is low.
module spi_par_receiver
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned LINES       = LINES_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [LINES-1:0]                    chip_data_in,
    input  logic                                chip_clk_in,
    input  logic                                chip_sel_in,
    output logic [LINES-1:0][DATA_WIDTH-1:0]    data_out,
    output logic                                data_valid_out,
    output logic                                frame_err_out,
    output logic [15:0]                         word_count_out
);

    localparam int unsigned CntW  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned FillW = $clog2(SYNC_STAGES + 1);
    localparam logic [CntW-1:0]  LastBit  = CntW'(DATA_WIDTH - 1);
    localparam logic [FillW-1:0] FillDone = FillW'(SYNC_STAGES);

    logic [LINES-1:0] data_s;
    logic             clk_s;
    logic             sel_s;

    for (genvar i = 0; i < LINES; i++) begin : g_sync_data
        synchronizer #(
            .DEPTH     (SYNC_STAGES),
            .RESET_VAL (1'b0)
        ) u_sync_data (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .d_in   (chip_data_in[i]),
            .q_out  (data_s[i])
        );
    end

    synchronizer #(
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_clk (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (chip_clk_in),
        .q_out  (clk_s)
    );

    synchronizer #(
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_sel (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (chip_sel_in),
        .q_out  (sel_s)
    );

    spi_state_e                      state_q, state_d;
    logic                            clk_prev_q;
    logic [LINES-1:0][DATA_WIDTH-1:0] shift_q, shift_d;
    logic [LINES-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [CntW-1:0]                 bit_cnt_q, bit_cnt_d;
    logic                            valid_q, valid_d;
    logic                            ferr_q, ferr_d;
    logic [15:0]                     word_count_q, word_count_d;
    logic [FillW-1:0]                fill_q, fill_d;
    logic                            armed_q, armed_d;
    logic                            clk_rise;

    assign clk_rise = clk_s & ~clk_prev_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        data_d       = data_q;
        bit_cnt_d    = bit_cnt_q;
        valid_d      = 1'b0;
        ferr_d       = 1'b0;
        word_count_d = word_count_q;
        fill_d       = fill_q;
        armed_d      = armed_q;

        // Until the select synchronizer has flushed its reset value, a high
        // select is not genuine; arming only on a real high select keeps a
        // transfer already in progress at reset release from being joined.
        if (fill_q != FillDone) begin
            fill_d = fill_q + 1'b1;
        end else if (sel_s) begin
            armed_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (armed_q && !sel_s) begin
                    state_d   = StRecv;
                    bit_cnt_d = '0;
                end
            end
            StRecv: begin
                if (sel_s) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    ferr_d    = (bit_cnt_q != '0);
                end else if (clk_rise) begin
                    for (int i = 0; i < LINES; i++) begin
                        shift_d[i] = {shift_q[i][DATA_WIDTH-2:0], data_s[i]};
                    end
                    if (bit_cnt_q == LastBit) begin
                        data_d       = shift_d;
                        valid_d      = 1'b1;
                        word_count_d = word_count_q + 16'd1;
                        bit_cnt_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            clk_prev_q   <= 1'b0;
            shift_q      <= '0;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            word_count_q <= '0;
            fill_q       <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_prev_q   <= clk_s;
            shift_q      <= shift_d;
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            word_count_q <= word_count_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign frame_err_out  = ferr_q;
    assign word_count_out = word_count_q;

endmodule
